alu_serial: RTL and testbench
=============================

# alu_serial

Bit-serial implementation of the team's 3-bit-opcode ALU (add, sub, and, or, xor), processing one operand bit per clock, LSB first. It sits behind a valid/ready command port and presents a registered result on a valid/ready result port. This lets area-constrained datapaths share the same op encoding as the parallel ALU, at the cost of W+2 cycles per operation.

## Interface
- W, 4: operand and result width in bits, W >= 1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i_op  in  3  opcode:
  - 001 add
  - 010 sub
  - 100 and
  - 101 or
  - 110 xor
  - all other codes are unsupported.
- i_a  in  W  operand A.
- i_b  in  W  operand B.
- i_ci  in  1  carry-in (add) or borrow-in (sub); ignored by logic ops.
- i_valid  in  1  command valid.
- o_ready  out  1  command ready; high only in IDLE.
- o_y  out  W  result.
- o_co  out  1  carry-out (add), borrow-out (sub), 0 otherwise.
- o_z  out  1  high when o_y == 0.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.

## Operation
- Only one clock and one reset. rst is asynchronous and active-high.
- FSM states and transitions:
  - IDLE → RUN on i_valid & o_ready. On that edge, latch op, a, b, ci into shift/control registers and clear the bit counter.
  - RUN: each edge processes bit cnt, shifting A and B right and shifting the result bit in at the MSB.
  - RUN → DONE on the edge processing bit W-1.
  - DONE: o_valid=1 and outputs held stable. On i_valid... no: on o_valid & i_ready, go DONE → IDLE.
- Arithmetic per bit, with carry register c:
  - add: c initialised to ci. y_k = a_k^b_k^c, c ← maj(a_k,b_k,c). o_co = final c.
  - sub: computed as a + ~b + ~ci, so c is initialised to ~ci and b_k is inverted. o_co = ~final c, which is 1 exactly when a < b + ci (unsigned).
  - and/or/xor: y_k = a_k op b_k, o_co = 0.
  - unsupported opcode: o_y = 0, o_co = 0, o_z = 1. The full handshake still completes.
- The result is modulo 2^W. o_z is computed on the final registered o_y.
- Commands are accepted in IDLE only. i_valid in RUN/DONE is ignored and not queued; the upstream must hold its command until accepted.
- Input operands are sampled only on the accept edge. Later changes to i_a, i_b, i_op or i_ci do not affect the operation in progress.
- o_y, o_co and o_z are stable while o_valid=1 until the handshake completes.

## Timing
- Reset state, async and applied immediately: state IDLE, counter 0, o_ready=1, o_valid=0, o_y=0, o_co=0, o_z=0. All shift and carry registers are 0.
- Reset mid-RUN or mid-DONE aborts the operation with no result. Outputs take reset values with no dependency on the clock. The first edge after rst deasserts can accept a command.
- Latency: command accepted on edge T. Bits are processed on edges T+1 … T+W, and o_valid rises after edge T+W.
- If i_ready=1 already, DONE → IDLE on edge T+W+1, and o_ready is high again after that edge.
- Peak throughput is one op per W+2 cycles.
- i_ready held low keeps DONE indefinitely with no output change.
- i_ready asserted outside DONE has no effect.
- No combinational path from i_valid or i_ready to o_ready or o_valid. All outputs are registered.
- W=1 degenerates correctly: RUN lasts one cycle and o_co is taken from the single bit.

## Test plan
- Basic add, W=4:
  - add, a=3, b=2, ci=0, i_ready=1 → o_valid exactly 4 edges after accept, with o_y=5, o_co=0, o_z=0.
  - add, a=15, b=1, ci=0 → o_y=0, o_co=1, o_z=1.
  - add, a=7, b=7, ci=1 → o_y=15, o_co=0.
- Sub:
  - a=1, b=2, ci=0 → o_y=15, o_co=1.
  - a=3, b=3, ci=0 → o_y=0, o_co=0, o_z=1.
  - a=3, b=2, ci=1 → o_y=0, o_co=0, o_z=1.
- Logic ops with a=12, b=10:
  - and → 8
  - or → 14
  - xor → 6
  - o_co=0 in every case.
  - op=000 → o_y=0, o_z=1, handshake completes.
- Backpressure: after add 3+2, hold i_ready=0 for 3 cycles while toggling i_valid and changing i_a, i_b → o_valid stays 1, o_y stays 5, o_ready stays 0, no new command is taken. Then raise i_ready → o_ready high on the next cycle.
- Operand isolation and sweep: change i_a and i_b every cycle during RUN → the result matches the values latched at accept. Sweep a, b ∈ 0..3 for every supported op, comparing against a reference model.
- Reset: assert rst two cycles into RUN of add 15+1 → o_valid=0, o_ready=1, o_y=0 immediately with no clock edge needed. After release, add 1+1 → o_y=2 with no residue of the aborted carry.

Source files
------------

// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial
// Description : Bit-serial ALU (add, sub, and, or, xor) behind valid/ready
//               command and result ports. One operand bit per clock, LSB
//               first; W+2 cycles per operation at peak throughput.
// Revision    : 1.0  initial release
// ============================================================================
module alu_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_y,
  output logic         o_co,
  output logic         o_z,
  output logic         o_valid,
  input  logic         i_ready
);

  // Counter needs at least one bit even when W == 1.
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [2:0]      op;
  logic [W-1:0]    sa;
  logic [W-1:0]    sb;
  logic [W-1:0]    y;
  logic            c;
  logic [CW-1:0]   cnt;
  logic            co;
  logic            z;

  logic            is_add;
  logic            is_sub;
  logic            last;
  logic            bit_b;
  logic            bit_y;
  logic            carry_nx;
  logic [W-1:0]    y_nx;

  assign is_add = (op == OP_ADD);
  assign is_sub = (op == OP_SUB);
  assign last   = (cnt == CW'(W - 1));

  // Subtraction is a + ~b + ~ci, so B is inverted bit by bit here.
  assign bit_b  = sb[0] ^ is_sub;

  // Result bit enters at the MSB so that after W shifts it is LSB-aligned.
  assign y_nx   = (y >> 1) | (W'(bit_y) << (W - 1));

  // Outputs are pure decodes of the state register: no path from inputs.
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_y     = y;
  assign o_co    = co;
  assign o_z     = z;

  // Per-bit result and carry for the current LSB of the operand shifters.
  always_comb begin
    bit_y    = 1'b0;
    carry_nx = c;
    case (op)
      OP_ADD, OP_SUB: begin
        bit_y    = sa[0] ^ bit_b ^ c;
        carry_nx = (sa[0] & bit_b) | (sa[0] & c) | (bit_b & c);
      end
      OP_AND:  bit_y = sa[0] & sb[0];
      OP_OR:   bit_y = sa[0] | sb[0];
      OP_XOR:  bit_y = sa[0] ^ sb[0];
      default: bit_y = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: accept in IDLE, run W bits, wait for result handshake.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_valid) state_nx = RUN;
      RUN:     if (last)    state_nx = DONE;
      DONE:    if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch on accept, shift one bit per RUN cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op  <= 3'b000;
      sa  <= '0;
      sb  <= '0;
      y   <= '0;
      c   <= 1'b0;
      cnt <= '0;
      co  <= 1'b0;
      z   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            op  <= i_op;
            sa  <= i_a;
            sb  <= i_b;
            c   <= (i_op == OP_SUB) ? ~i_ci : i_ci;
            cnt <= '0;
            y   <= '0;
            co  <= 1'b0;
            z   <= 1'b0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= carry_nx;
          y   <= y_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            // Borrow-out is the inverse of the final carry for a + ~b + ~ci.
            co <= is_add ? carry_nx : (is_sub ? ~carry_nx : 1'b0);
            z  <= (y_nx == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial
// Description : Self-checking bench for alu_serial (W=4) with a behavioural
//               arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_ci;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] o_y;
  logic         o_co;
  logic         o_z;
  logic         o_valid;
  logic         i_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] y;
    logic         co;
    logic         z;
  } vec_t;

  always #5 clk = ~clk;

  alu_serial #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_ci    (i_ci),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_y     (o_y),
    .o_co    (o_co),
    .o_z     (o_z),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  // Reference: returns {z, co, y} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic ci);
    int           r;
    logic [W-1:0] y;
    logic         co;
    y  = '0;
    co = 1'b0;
    case (op)
      3'b001: begin r = int'(a) + int'(b) + int'(ci); y = W'(r); co = (r >= (1 << W)); end
      3'b010: begin r = int'(a) - int'(b) - int'(ci); y = W'(r); co = (r < 0); end
      3'b100: y = a & b;
      3'b101: y = a | b;
      3'b110: y = a ^ b;
      default: y = '0;
    endcase
    return {(y == '0), co, y};
  endfunction

  // Issue one command; optionally scramble inputs after accept. Returns the
  // result seen when o_valid rises, the edge count from accept, and (if
  // rdy) whether the block was back in IDLE one edge later.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input bit scramble, input bit rdy,
                       output logic [W-1:0] y, output logic co, output logic z,
                       output int lat, output logic idle_after);
    @(negedge clk);
    i_op = op; i_a = a; i_b = b; i_ci = ci; i_valid = 1'b1; i_ready = rdy;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 50) begin
      if (scramble) begin
        i_a = W'($urandom); i_b = W'($urandom); i_op = 3'($urandom); i_ci = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    y = o_y; co = o_co; z = o_z;
    idle_after = 1'b0;
    if (rdy) begin
      @(posedge clk); #1;
      idle_after = o_ready & ~o_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_op = '0; i_a = '0; i_b = '0; i_ci = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    #2;
    checks++;
    if ({o_ready, o_valid, o_y, o_co, o_z} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b y=%0d co=%b z=%b, want rdy=1 vld=0 y=0 co=0 z=0",
               o_ready, o_valid, o_y, o_co, o_z);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[10];
    logic [W-1:0] y;
    logic co, z, idl;
    int lat;
    v[0] = '{3'b001, 4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0};
    v[1] = '{3'b001, 4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b1};
    v[2] = '{3'b001, 4'd7,  4'd7,  1'b1, 4'd15, 1'b0, 1'b0};
    v[3] = '{3'b010, 4'd1,  4'd2,  1'b0, 4'd15, 1'b1, 1'b0};
    v[4] = '{3'b010, 4'd3,  4'd3,  1'b0, 4'd0,  1'b0, 1'b1};
    v[5] = '{3'b010, 4'd3,  4'd2,  1'b1, 4'd0,  1'b0, 1'b1};
    v[6] = '{3'b100, 4'd12, 4'd10, 1'b1, 4'd8,  1'b0, 1'b0};
    v[7] = '{3'b101, 4'd12, 4'd10, 1'b0, 4'd14, 1'b0, 1'b0};
    v[8] = '{3'b110, 4'd12, 4'd10, 1'b1, 4'd6,  1'b0, 1'b0};
    v[9] = '{3'b000, 4'd12, 4'd10, 1'b1, 4'd0,  1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].ci, 1'b0, 1'b1, y, co, z, lat, idl);
      checks++;
      if (lat !== W) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, W);
      end
      checks++;
      if ({y, co, z} !== {v[i].y, v[i].co, v[i].z}) begin
        failures++;
        $display("FAIL directed_result[%0d] op=%b a=%0d b=%0d ci=%b: got y=%0d co=%b z=%b, want y=%0d co=%b z=%b",
                 i, v[i].op, v[i].a, v[i].b, v[i].ci, y, co, z, v[i].y, v[i].co, v[i].z);
      end
      checks++;
      if (idl !== 1'b1) begin
        failures++;
        $display("FAIL directed_idle_after[%0d]: got %b, want 1", i, idl);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] y;
    logic co, z, idl;
    int lat;
    do_op(3'b001, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0, y, co, z, lat, idl);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = ~i_valid; i_a = W'($urandom); i_b = W'($urandom); i_op = 3'b001;
      @(posedge clk); #1;
      checks++;
      if ({o_valid, o_ready, o_y, o_co, o_z} !== {1'b1, 1'b0, 4'd5, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b y=%0d co=%b z=%b, want vld=1 rdy=0 y=5 co=0 z=0",
                 i, o_valid, o_ready, o_y, o_co, o_z);
      end
    end
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({o_ready, o_valid} !== 2'b10) begin
      failures++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b, want rdy=1 vld=0", o_ready, o_valid);
    end
  endtask

  task automatic test_sweep();
    logic [2:0]   ops[5] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    logic [W-1:0] y;
    logic [W+1:0] e;
    logic co, z, idl;
    int lat;
    for (int o = 0; o < 5; o++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          logic ci;
          ci = 1'((a + b + o) & 1);
          e  = ref_alu(ops[o], W'(a), W'(b), ci);
          do_op(ops[o], W'(a), W'(b), ci, 1'b1, 1'b1, y, co, z, lat, idl);
          checks++;
          if ({z, co, y} !== e) begin
            failures++;
            $display("FAIL sweep op=%b a=%0d b=%0d ci=%b: got y=%0d co=%b z=%b, want y=%0d co=%b z=%b",
                     ops[o], a, b, ci, y, co, z, e[W-1:0], e[W], e[W+1]);
          end
        end
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [W-1:0] a, b, y;
    logic [W+1:0] e;
    logic ci, co, z, idl;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom); a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      e  = ref_alu(op, a, b, ci);
      do_op(op, a, b, ci, 1'b1, 1'b1, y, co, z, lat, idl);
      checks++;
      if ({z, co, y} !== e || lat !== W || idl !== 1'b1) begin
        failures++;
        $display("FAIL random[%0d] op=%b a=%0d b=%0d ci=%b: got y=%0d co=%b z=%b lat=%0d idle=%b, want y=%0d co=%b z=%b lat=%0d idle=1",
                 i, op, a, b, ci, y, co, z, lat, idl, e[W-1:0], e[W], e[W+1], W);
      end
    end
  endtask

  task automatic test_midrun_reset();
    logic [W-1:0] y;
    logic co, z, idl;
    int lat;
    @(negedge clk);
    i_op = 3'b001; i_a = 4'd15; i_b = 4'd1; i_ci = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({o_ready, o_valid, o_y, o_co, o_z} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrun_reset_async: got rdy=%b vld=%b y=%0d co=%b z=%b, want rdy=1 vld=0 y=0 co=0 z=0",
               o_ready, o_valid, o_y, o_co, o_z);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(3'b001, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1, y, co, z, lat, idl);
    checks++;
    if ({y, co, z} !== {4'd2, 1'b0, 1'b0} || lat !== W) begin
      failures++;
      $display("FAIL after_reset_add: got y=%0d co=%b z=%b lat=%0d, want y=2 co=0 z=0 lat=%0d",
               y, co, z, lat, W);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_sweep();
    test_random();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
